pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit. Splits a DATA_WIDTH operand pair into STAGES
//  equal slices, adds one slice per clock with the carry registered between slices, and
//  delivers a DATA_WIDTH+1 result with carry and signed-overflow flags. It sits in datapaths
//  that need full-width adds at clock rates a single ripple chain cannot meet.
//  Valid/ready on both sides; one result per cycle when not back-pressured.
// PARAMETERS
//  DATA_WIDTH  8  operand width in bits; must be a multiple of STAGES
//  STAGES      4  pipeline depth = number of slices; SLICE = DATA_WIDTH/STAGES; 1 allowed
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  in_valid   in   1             operand beat valid
//  in_ready   out  1             unit can accept a beat this cycle
//  a          in   DATA_WIDTH    operand A
//  b          in   DATA_WIDTH    operand B
//  cin        in   1             carry-in (add mode only; ignored when sub=1)
//  sub        in   1             0: a+b+cin   1: a-b (a+~b+1)
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts result
//  sum        out  DATA_WIDTH+1  {carry_out, result}; sub: sum[DATA_WIDTH]=1 means no borrow
//  overflow   out  1             signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: every stage valid bit, data, carry register cleared; out_valid=0, sum=0,
//    overflow=0; in_ready=1 once reset deasserts. Reset mid-operation discards all beats.
//  - Global advance: en = !out_valid || out_ready; in_ready = en (combinational).
//    When en=0 every pipeline register holds; no beat is lost or duplicated.
//  - Accept: beat taken on a clk edge with in_valid && in_ready. b_eff = sub ? ~b : b,
//    c0 = sub ? 1 : cin, computed at the input before stage 0.
//  - Stage j (0..STAGES-1) adds slice j of a and b_eff plus the registered carry from stage
//    j-1 (c0 for j=0). Unused upper slices travel skewed through stage registers; finished
//    lower slices are delayed so all slices of a beat leave together.
//  - Final stage registers sum[DATA_WIDTH-1:0], carry out (sum[DATA_WIDTH]) and overflow.
//  - Latency: accepted at edge t -> out_valid at edge t+STAGES with no stall; each stall
//    cycle adds one. Throughput 1 beat/cycle with out_ready held high.
//  - Stage valid bits shift with en; a bubble (in_valid=0 while en=1) propagates as a
//    bubble. No bubble squeezing: a stall freezes the whole pipe even if stages are empty.
//  - out_valid/sum/overflow stable while out_valid && !out_ready.
//  - Simultaneous accept and output handshake in one cycle is legal and normal.
//  - Arithmetic is modulo 2^DATA_WIDTH on sum[DATA_WIDTH-1:0]; carry and overflow per
//    definitions above; no saturation. Each beat uses its own sub/cin; modes may change
//    every beat.
//  - STAGES=1: single registered adder, latency 1, same handshake.
// TESTING (DATA_WIDTH=8, STAGES=4 unless stated)
//  1 add a=0xFF b=0x01 cin=0, out_ready=1 -> 4 cycles later sum=0x100, overflow=0
//  2 add a=0x7F b=0x01 cin=0 -> sum=0x080, overflow=1; a=0x7F b=0x00 cin=1 -> sum=0x080,
//    overflow=1
//  3 sub a=0x05 b=0x07 -> sum=0x0FE (borrow), overflow=0; sub a=0x80 b=0x01 -> sum=0x17F,
//    overflow=1
//  4 stream 16 random beats back-to-back, out_ready=1 -> 16 results on consecutive cycles
//    in order, all match reference model
//  5 out_ready=0 for 6 cycles with pipe full -> in_ready=0, sum held stable; release ->
//    results resume in order, none lost
//  6 assert reset with 3 beats in flight -> out_valid=0 and sum=0 immediately; after
//    release first new beat emerges after 4 cycles; repeat 1-4 with STAGES=1 and STAGES=8
//    (DATA_WIDTH=16)

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Pipelined add/subtract unit. The DATA_WIDTH operands are cut into STAGES equal
//   slices. One slice is added per clock, and the slice carry is registered between
//   stages. The result is DATA_WIDTH+1 bits wide, with carry-out on top, plus a
//   signed-overflow flag.
//
//   Register layout (index i = 0..STAGES):
//     i = 0        input register: a, b_eff (= ~b for subtract), c0 (= 1 for subtract)
//     i = j+1      output of adder stage j: slice j of the result plus its carry-out
//   As a result, a beat accepted at edge t is presented at edge t+STAGES.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears every stage
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle (combinational)
//   a, b       operands, DATA_WIDTH bits
//   cin        carry-in; used in add mode only
//   sub        0: a+b+cin   1: a-b computed as a+~b+1
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        {carry_out, result}; when subtracting, sum[DATA_WIDTH]=1 means no borrow
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
module pipelined_adder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   sum,
  output logic                  overflow
);

  localparam int unsigned Slice = DATA_WIDTH / STAGES;

  // Index 0 is the input register. Index j+1 holds the state after adder stage j.
  logic                  v_q [0:STAGES];
  logic                  v_d [0:STAGES];
  logic [DATA_WIDTH-1:0] a_q [0:STAGES];
  logic [DATA_WIDTH-1:0] a_d [0:STAGES];
  logic [DATA_WIDTH-1:0] b_q [0:STAGES];
  logic [DATA_WIDTH-1:0] b_d [0:STAGES];
  logic [DATA_WIDTH-1:0] r_q [0:STAGES];
  logic [DATA_WIDTH-1:0] r_d [0:STAGES];
  logic                  c_q [0:STAGES];
  logic                  c_d [0:STAGES];
  logic                  ovf_q;
  logic                  ovf_d;

  logic                  en;
  logic [Slice:0]        slice_sum;

  always_comb begin
    // A stalled output freezes the entire pipe. Empty stages are not squeezed out.
    en = !v_q[STAGES] || out_ready;

    for (int i = 0; i <= STAGES; i++) begin
      v_d[i] = v_q[i];
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
      r_d[i] = r_q[i];
      c_d[i] = c_q[i];
    end
    ovf_d     = ovf_q;
    slice_sum = '0;

    if (en) begin
      v_d[0] = in_valid;
      a_d[0] = a;
      b_d[0] = sub ? ~b : b;
      c_d[0] = sub | cin;
      r_d[0] = '0;

      for (int j = 0; j < STAGES; j++) begin
        slice_sum = {1'b0, a_q[j][j*Slice +: Slice]}
                  + {1'b0, b_q[j][j*Slice +: Slice]}
                  + {{Slice{1'b0}}, c_q[j]};
        // Operands skew forward untouched. Only slice j of the result is filled here.
        v_d[j+1]                   = v_q[j];
        a_d[j+1]                   = a_q[j];
        b_d[j+1]                   = b_q[j];
        r_d[j+1]                   = r_q[j];
        r_d[j+1][j*Slice +: Slice] = slice_sum[Slice-1:0];
        c_d[j+1]                   = slice_sum[Slice];
      end

      // slice_sum now holds the top slice. The carry into the MSB equals a^b^sum at that bit.
      ovf_d = slice_sum[Slice]
            ^ a_q[STAGES-1][DATA_WIDTH-1]
            ^ b_q[STAGES-1][DATA_WIDTH-1]
            ^ slice_sum[Slice-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= STAGES; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
        c_q[i] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i <= STAGES; i++) begin
        v_q[i] <= v_d[i];
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        r_q[i] <= r_d[i];
        c_q[i] <= c_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[STAGES];
  assign sum       = {c_q[STAGES], r_q[STAGES]};
  assign overflow  = ovf_q;

endmodule
